// File: rtl/bus_pkg.sv
// Shared types and constants for the two-port TileLink-UL bus arbiter.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        A_PHASE = 2'b01,
        D_WAIT  = 2'b10
    } arb_state_e;

    // Owner encodings, also visible on the owner debug port
    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_IF   = 2'b01;
    localparam logic [1:0] OWN_MA   = 2'b10;

    // TileLink-UL opcodes
    localparam logic [2:0] TL_GET             = 3'd4;
    localparam logic [2:0] TL_PUT_FULL_DATA   = 3'd0;
    localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

endpackage

// File: rtl/tl_if.sv
// TileLink-UL A/D channel bundle with master and slave views.
interface tl_if #(
    parameter int AW = 64,
    parameter int DW = 64
);
    logic            a_valid;
    logic            a_ready;
    logic [2:0]      a_opcode;
    logic [AW-1:0]   a_address;
    logic [DW-1:0]   a_data;
    logic [DW/8-1:0] a_mask;
    logic            d_valid;
    logic            d_ready;
    logic [2:0]      d_opcode;
    logic [DW-1:0]   d_data;

    modport master (
        output a_valid, a_opcode, a_address, a_data, a_mask, d_ready,
        input  a_ready, d_valid, d_opcode, d_data
    );

    modport slave (
        input  a_valid, a_opcode, a_address, a_data, a_mask, d_ready,
        output a_ready, d_valid, d_opcode, d_data
    );
endinterface

// File: rtl/arb_pick.sv
// Winner selection between the fetch and access request lines.
// With BUS_ARB_RR_EN the port granted last loses the next tie;
// otherwise access always beats fetch.
module arb_pick
    import bus_pkg::*;
(
    input  logic       if_req,
    input  logic       ma_req,
`ifdef BUS_ARB_RR_EN
    input  logic [1:0] last_owner,
`endif
    output logic [1:0] pick
);

    // Pick the winner for the current cycle's requests
    always_comb begin
        pick = OWN_NONE;
        if (if_req && ma_req) begin
`ifdef BUS_ARB_RR_EN
            if (last_owner == OWN_IF) begin
                pick = OWN_MA;
            end else begin
                pick = OWN_IF;
            end
`else
            pick = OWN_MA;
`endif
        end else if (ma_req) begin
            pick = OWN_MA;
        end else if (if_req) begin
            pick = OWN_IF;
        end else begin
            pick = OWN_NONE;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Merges the CPU fetch (if) and access (ma) TileLink-UL ports onto one
// memory-side port with a single outstanding transaction.
// Optional macro BUS_ARB_RR_EN: round-robin tie-break instead of ma-first.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int AW = 64,
    parameter int DW = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       if_request,
    tl_if.slave        if_bus,
    input  logic       ma_request,
    tl_if.slave        ma_bus,
    tl_if.master       mem_bus,
    output logic [1:0] owner
);

    arb_state_e      state_r, state_nxt_s;
    logic [1:0]      owner_r, owner_nxt_s, pick_s;
    logic            drop_r, drop_nxt_s, drop_s;
    logic            own_req_s, a_hs_s, d_hs_s, if_clear_s;
    logic            a_src_valid_s, mem_a_valid_s, mem_d_ready_s;
    logic            if_a_ready_s, ma_a_ready_s, if_d_valid_s, ma_d_valid_s;
    logic [2:0]      a_opcode_s;
    logic [AW-1:0]   a_address_s;
    logic [DW-1:0]   a_data_s;
    logic [DW/8-1:0] a_mask_s;
`ifdef BUS_ARB_RR_EN
    logic [1:0]      last_owner_r;
`endif

    arb_pick u_pick (
        .if_req     (if_request),
        .ma_req     (ma_request),
`ifdef BUS_ARB_RR_EN
        .last_owner (last_owner_r),
`endif
        .pick       (pick_s)
    );

    // A-channel source mux; fields follow the owner so they stay stable under backpressure
    always_comb begin
        a_src_valid_s = 1'b0;
        a_opcode_s    = TL_GET;
        a_address_s   = {AW{1'b0}};
        a_data_s      = {DW{1'b0}};
        a_mask_s      = {(DW/8){1'b0}};
        own_req_s     = 1'b0;
        case (owner_r)
            OWN_IF: begin
                a_src_valid_s = if_bus.a_valid;
                a_opcode_s    = if_bus.a_opcode;
                a_address_s   = if_bus.a_address;
                a_data_s      = if_bus.a_data;
                a_mask_s      = if_bus.a_mask;
                own_req_s     = if_request;
            end
            OWN_MA: begin
                a_src_valid_s = ma_bus.a_valid;
                a_opcode_s    = ma_bus.a_opcode;
                a_address_s   = ma_bus.a_address;
                a_data_s      = ma_bus.a_data;
                a_mask_s      = ma_bus.a_mask;
                own_req_s     = ma_request;
            end
            default: begin
                a_src_valid_s = 1'b0;
                own_req_s     = 1'b0;
            end
        endcase
    end

    // A flush only matters for a fetch transaction; the D beat is then swallowed
    assign if_clear_s = clear && (owner_r == OWN_IF);
    assign drop_s     = drop_r || (if_clear_s && (state_r == D_WAIT));

    // Per-port handshake routing; non-owners always see ready/valid low
    always_comb begin
        if_a_ready_s  = 1'b0;
        ma_a_ready_s  = 1'b0;
        if_d_valid_s  = 1'b0;
        ma_d_valid_s  = 1'b0;
        mem_d_ready_s = 1'b0;
        if (state_r == A_PHASE) begin
            if_a_ready_s = (owner_r == OWN_IF) && mem_bus.a_ready;
            ma_a_ready_s = (owner_r == OWN_MA) && mem_bus.a_ready;
        end else if (state_r == D_WAIT) begin
            if (owner_r == OWN_IF) begin
                if_d_valid_s  = mem_bus.d_valid && !drop_s;
                mem_d_ready_s = drop_s || if_bus.d_ready;
            end else if (owner_r == OWN_MA) begin
                ma_d_valid_s  = mem_bus.d_valid;
                mem_d_ready_s = ma_bus.d_ready;
            end else begin
                mem_d_ready_s = 1'b0;
            end
        end else begin
            mem_d_ready_s = 1'b0;
        end
    end

    assign mem_a_valid_s = (state_r == A_PHASE) && a_src_valid_s;
    assign a_hs_s        = mem_a_valid_s && mem_bus.a_ready;
    assign d_hs_s        = (state_r == D_WAIT) && mem_bus.d_valid && mem_d_ready_s;

    assign mem_bus.a_valid   = mem_a_valid_s;
    assign mem_bus.a_opcode  = a_opcode_s;
    assign mem_bus.a_address = a_address_s;
    assign mem_bus.a_data    = a_data_s;
    assign mem_bus.a_mask    = a_mask_s;
    assign mem_bus.d_ready   = mem_d_ready_s;
    assign if_bus.a_ready    = if_a_ready_s;
    assign ma_bus.a_ready    = ma_a_ready_s;
    assign if_bus.d_valid    = if_d_valid_s;
    assign ma_bus.d_valid    = ma_d_valid_s;
    assign if_bus.d_opcode   = mem_bus.d_opcode;
    assign ma_bus.d_opcode   = mem_bus.d_opcode;
    assign if_bus.d_data     = mem_bus.d_data;
    assign ma_bus.d_data     = mem_bus.d_data;
    assign owner             = owner_r;

    // Next state, owner and drop flag; D beats outside D_WAIT are ignored
    always_comb begin
        state_nxt_s = state_r;
        owner_nxt_s = owner_r;
        drop_nxt_s  = drop_r;
        case (state_r)
            IDLE: begin
                drop_nxt_s = 1'b0;
                if (pick_s != OWN_NONE) begin
                    owner_nxt_s = pick_s;
                    state_nxt_s = A_PHASE;
                end else begin
                    owner_nxt_s = OWN_NONE;
                end
            end
            A_PHASE: begin
                if (a_hs_s) begin
                    state_nxt_s = D_WAIT;
                    drop_nxt_s  = if_clear_s;
                end else if (!own_req_s || if_clear_s) begin
                    state_nxt_s = IDLE;
                    owner_nxt_s = OWN_NONE;
                end else begin
                    state_nxt_s = A_PHASE;
                end
            end
            D_WAIT: begin
                if (d_hs_s) begin
                    state_nxt_s = IDLE;
                    owner_nxt_s = OWN_NONE;
                    drop_nxt_s  = 1'b0;
                end else begin
                    drop_nxt_s  = drop_s;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                owner_nxt_s = OWN_NONE;
                drop_nxt_s  = 1'b0;
            end
        endcase
    end

    // Arbiter state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            owner_r <= OWN_NONE;
            drop_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            owner_r <= owner_nxt_s;
            drop_r  <= drop_nxt_s;
        end
    end

`ifdef BUS_ARB_RR_EN
    // Remember the last grant; starts at ma so fetch wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner_r <= OWN_MA;
        end else if ((state_r == IDLE) && (pick_s != OWN_NONE)) begin
            last_owner_r <= pick_s;
        end else begin
            last_owner_r <= last_owner_r;
        end
    end
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: stimulus pushes expected A beats,
// D responses and grants; a negedge monitor pops and compares them.
module tb_bus_arbiter;
    import bus_pkg::*;

    typedef struct packed {
        logic [2:0]  op;
        logic [63:0] addr;
        logic [63:0] data;
        logic [7:0]  mask;
    } a_exp_t;
    typedef struct packed {
        logic [2:0]  op;
        logic [63:0] data;
    } d_t;
    typedef struct packed {
        logic [1:0] who;
        logic       back;
    } g_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       if_request = 1'b0;
    logic       ma_request = 1'b0;
    logic [1:0] owner;

    tl_if #(.AW(64), .DW(64)) if_bus ();
    tl_if #(.AW(64), .DW(64)) ma_bus ();
    tl_if #(.AW(64), .DW(64)) mem_bus ();

    bus_arbiter #(.AW(64), .DW(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .if_request (if_request),
        .if_bus     (if_bus),
        .ma_request (ma_request),
        .ma_bus     (ma_bus),
        .mem_bus    (mem_bus),
        .owner      (owner)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int last_dhs = -100;
    int a_stall_cfg = 0;
    int d_delay_cfg = 1;
    bit watch_quiet = 1'b0;
    bit watch_drop = 1'b0;

    a_exp_t exp_a[$];
    d_t     exp_if_d[$];
    d_t     exp_ma_d[$];
    d_t     mem_resp[$];
    g_t     exp_g[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got an unexpected beat expected none (cycle %0d)", name, cyc);
    endtask

    // Queue one transaction: drive the master port and record what must follow
    task automatic txn(input bit is_ma, input bit back, input bit delivered,
                       input logic [2:0] op, input logic [63:0] addr, input logic [63:0] data,
                       input logic [7:0] mask, input logic [2:0] rop, input logic [63:0] rdata);
        a_exp_t ea;
        d_t     ed;
        g_t     eg;
        ea.op = op; ea.addr = addr; ea.data = data; ea.mask = mask;
        ed.op = rop; ed.data = rdata;
        eg.who = is_ma ? OWN_MA : OWN_IF;
        eg.back = back;
        exp_a.push_back(ea);
        exp_g.push_back(eg);
        mem_resp.push_back(ed);
        if (is_ma) begin
            if (delivered) exp_ma_d.push_back(ed);
            ma_bus.a_opcode = op; ma_bus.a_address = addr; ma_bus.a_data = data;
            ma_bus.a_mask = mask; ma_bus.a_valid = 1'b1; ma_request = 1'b1;
        end else begin
            if (delivered) exp_if_d.push_back(ed);
            if_bus.a_opcode = op; if_bus.a_address = addr; if_bus.a_data = data;
            if_bus.a_mask = mask; if_bus.a_valid = 1'b1; if_request = 1'b1;
        end
    endtask

    // Wait until every expectation is consumed and the bus is released
    task automatic wait_done(input string name, input int budget);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
            done = (owner == OWN_NONE) && (exp_a.size() == 0) && (exp_g.size() == 0) &&
                   (mem_resp.size() == 0) && (exp_if_d.size() == 0) &&
                   (exp_ma_d.size() == 0) && !mem_bus.d_valid;
        end
        check({name, "_complete"}, {63'd0, done}, 64'd1);
        @(posedge clk);
        #1;
    endtask

    // Fetch master: drop valid and request after its A handshake
    initial begin : if_master
        bit hs;
        forever begin
            @(negedge clk);
            hs = if_bus.a_valid && if_bus.a_ready;
            @(posedge clk);
            #1;
            if (hs) begin if_bus.a_valid = 1'b0; if_request = 1'b0; end
        end
    end

    // Access master: drop valid and request after its A handshake
    initial begin : ma_master
        bit hs;
        forever begin
            @(negedge clk);
            hs = ma_bus.a_valid && ma_bus.a_ready;
            @(posedge clk);
            #1;
            if (hs) begin ma_bus.a_valid = 1'b0; ma_request = 1'b0; end
        end
    end

    // Memory responder: stalls A for a_stall_cfg cycles, answers D after d_delay_cfg
    initial begin : mem_model
        bit a_hs, a_wait, d_hs, armed;
        int stall, dcnt;
        stall = 0; dcnt = 0; armed = 1'b0;
        forever begin
            @(negedge clk);
            a_hs   = mem_bus.a_valid && mem_bus.a_ready;
            a_wait = mem_bus.a_valid && !mem_bus.a_ready;
            d_hs   = mem_bus.d_valid && mem_bus.d_ready;
            @(posedge clk);
            #1;
            if (a_hs) begin
                mem_bus.a_ready = 1'b0; stall = 0; armed = 1'b1; dcnt = d_delay_cfg;
            end else if (a_wait) begin
                if (stall >= a_stall_cfg) mem_bus.a_ready = 1'b1;
                else stall++;
            end
            if (d_hs) begin
                mem_bus.d_valid = 1'b0;
                if (mem_resp.size() > 0) void'(mem_resp.pop_front());
            end else if (armed && !mem_bus.d_valid) begin
                if (dcnt <= 1) begin
                    if (mem_resp.size() > 0) begin
                        mem_bus.d_valid  = 1'b1;
                        mem_bus.d_opcode = mem_resp[0].op;
                        mem_bus.d_data   = mem_resp[0].data;
                    end
                    armed = 1'b0;
                end else begin
                    dcnt--;
                end
            end
        end
    end

    // Monitor: compares every DUT beat and grant against the scoreboard queues
    initial begin : monitor
        a_exp_t ea;
        d_t     ed;
        g_t     eg;
        logic [1:0] prev_owner;
        bit prev_stall;
        prev_owner = OWN_NONE;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (prev_stall) check("a_valid_held", {63'd0, mem_bus.a_valid}, 64'd1);
                if (mem_bus.a_valid) begin
                    if (exp_a.size() == 0) begin
                        unexpected("mem_a_beat");
                    end else begin
                        ea = exp_a[0];
                        check("a_opcode", {61'd0, mem_bus.a_opcode}, {61'd0, ea.op});
                        check("a_address", mem_bus.a_address, ea.addr);
                        check("a_data", mem_bus.a_data, ea.data);
                        check("a_mask", {56'd0, mem_bus.a_mask}, {56'd0, ea.mask});
                        if (mem_bus.a_ready) void'(exp_a.pop_front());
                    end
                end
                if (if_bus.d_valid && if_bus.d_ready) begin
                    if (exp_if_d.size() == 0) begin
                        unexpected("if_d_beat");
                    end else begin
                        ed = exp_if_d.pop_front();
                        check("if_d_opcode", {61'd0, if_bus.d_opcode}, {61'd0, ed.op});
                        check("if_d_data", if_bus.d_data, ed.data);
                    end
                end
                if (ma_bus.d_valid && ma_bus.d_ready) begin
                    if (exp_ma_d.size() == 0) begin
                        unexpected("ma_d_beat");
                    end else begin
                        ed = exp_ma_d.pop_front();
                        check("ma_d_opcode", {61'd0, ma_bus.d_opcode}, {61'd0, ed.op});
                        check("ma_d_data", ma_bus.d_data, ed.data);
                    end
                end
                if (mem_bus.d_valid && mem_bus.d_ready) last_dhs = cyc + 1;
                if ((owner != prev_owner) && (owner != OWN_NONE)) begin
                    if (exp_g.size() == 0) begin
                        unexpected("grant");
                    end else begin
                        eg = exp_g.pop_front();
                        check("grant_owner", {62'd0, owner}, {62'd0, eg.who});
                        if (eg.back) check("grant_gap_after_d", 64'(cyc - last_dhs), 64'd1);
                    end
                end
                if (watch_quiet && (owner == OWN_MA)) begin
                    check("if_a_ready_isolated", {63'd0, if_bus.a_ready}, 64'd0);
                    check("if_d_valid_isolated", {63'd0, if_bus.d_valid}, 64'd0);
                end
                if (watch_drop && mem_bus.d_valid) begin
                    check("drop_mem_d_ready", {63'd0, mem_bus.d_ready}, 64'd1);
                    check("drop_if_d_valid", {63'd0, if_bus.d_valid}, 64'd0);
                end
                prev_stall = mem_bus.a_valid && !mem_bus.a_ready;
                prev_owner = owner;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        if_bus.a_valid = 1'b0; if_bus.a_opcode = 3'd0; if_bus.a_address = 64'd0;
        if_bus.a_data = 64'd0; if_bus.a_mask = 8'd0; if_bus.d_ready = 1'b1;
        ma_bus.a_valid = 1'b0; ma_bus.a_opcode = 3'd0; ma_bus.a_address = 64'd0;
        ma_bus.a_data = 64'd0; ma_bus.a_mask = 8'd0; ma_bus.d_ready = 1'b1;
        mem_bus.a_ready = 1'b0; mem_bus.d_valid = 1'b0;
        mem_bus.d_opcode = 3'd0; mem_bus.d_data = 64'd0;

        // 1. Reset then idle, with a stray D beat that must not be forwarded
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_owner", {62'd0, owner}, 64'd0);
        check("rst_mem_a_valid", {63'd0, mem_bus.a_valid}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mem_bus.d_valid = 1'b1; mem_bus.d_opcode = TL_ACCESS_ACK_DATA; mem_bus.d_data = 64'h55;
        repeat (2) @(negedge clk);
        check("idle_owner", {62'd0, owner}, 64'd0);
        check("idle_mem_a_valid", {63'd0, mem_bus.a_valid}, 64'd0);
        check("idle_mem_d_ready", {63'd0, mem_bus.d_ready}, 64'd0);
        check("idle_if_a_ready", {63'd0, if_bus.a_ready}, 64'd0);
        check("idle_ma_a_ready", {63'd0, ma_bus.a_ready}, 64'd0);
        check("idle_if_d_valid", {63'd0, if_bus.d_valid}, 64'd0);
        check("idle_ma_d_valid", {63'd0, ma_bus.d_valid}, 64'd0);
        @(posedge clk);
        #1;
        mem_bus.d_valid = 1'b0;
        @(posedge clk);
        #1;

        // 3. Simultaneous requests (run first so round-robin starts from reset)
`ifdef BUS_ARB_RR_EN
        txn(1'b0, 1'b0, 1'b1, TL_GET, 64'h100, 64'd0, 8'hFF, TL_ACCESS_ACK_DATA, 64'h11);
        txn(1'b1, 1'b1, 1'b1, TL_GET, 64'h200, 64'd0, 8'hFF, TL_ACCESS_ACK_DATA, 64'hA2);
`else
        txn(1'b1, 1'b0, 1'b1, TL_GET, 64'h200, 64'd0, 8'hFF, TL_ACCESS_ACK_DATA, 64'hA2);
        txn(1'b0, 1'b1, 1'b1, TL_GET, 64'h100, 64'd0, 8'hFF, TL_ACCESS_ACK_DATA, 64'h11);
`endif
        wait_done("t3_simultaneous", 100);

        // 2. Single fetch: owner=01 one edge after the request, D after 3 cycles
        d_delay_cfg = 3;
        txn(1'b0, 1'b0, 1'b1, TL_GET, 64'h8000_0000, 64'd0, 8'hFF, TL_ACCESS_ACK_DATA, 64'h13);
        @(negedge clk);
        check("t2_owner_before_edge", {62'd0, owner}, 64'd0);
        @(negedge clk);
        check("t2_owner_after_edge", {62'd0, owner}, {62'd0, OWN_IF});
        wait_done("t2_single_fetch", 100);

        // 4. Flush during a fetch in D_WAIT, with access pending
        d_delay_cfg = 4;
        if_bus.d_ready = 1'b0;
        txn(1'b0, 1'b0, 1'b0, TL_GET, 64'h300, 64'd0, 8'hFF, TL_ACCESS_ACK_DATA, 64'hBAD);
        n = 0;
        while (!((owner == OWN_IF) && (exp_a.size() == 0)) && (n < 50)) begin
            @(negedge clk);
            n++;
        end
        check("t4_reached_d_wait", {63'd0, n < 50}, 64'd1);
        @(posedge clk);
        #1;
        clear = 1'b1;
        watch_drop = 1'b1;
        txn(1'b1, 1'b1, 1'b1, TL_GET, 64'h400, 64'd0, 8'hFF, TL_ACCESS_ACK_DATA, 64'h44);
        @(posedge clk);
        #1;
        clear = 1'b0;
        wait_done("t4_flush", 100);
        watch_drop = 1'b0;
        if_bus.d_ready = 1'b1;
        d_delay_cfg = 1;

        // 5. Store isolation: ma PutFullData while fetch keeps requesting
        txn(1'b1, 1'b0, 1'b1, TL_PUT_FULL_DATA, 64'h1000, 64'hDEAD_BEEF, 8'h0F, TL_ACCESS_ACK, 64'd0);
        n = 0;
        while ((owner != OWN_MA) && (n < 50)) begin
            @(negedge clk);
            n++;
        end
        check("t5_ma_granted", {63'd0, n < 50}, 64'd1);
        @(posedge clk);
        #1;
        watch_quiet = 1'b1;
        txn(1'b0, 1'b1, 1'b1, TL_GET, 64'h2000, 64'd0, 8'hFF, TL_ACCESS_ACK_DATA, 64'h77);
        wait_done("t5_isolation", 100);
        watch_quiet = 1'b0;

        // 6. Backpressure: a_ready held low for 5 A_PHASE cycles
        a_stall_cfg = 4;
        txn(1'b1, 1'b0, 1'b1, TL_PUT_FULL_DATA, 64'h3000, 64'h0123_4567_89AB_CDEF, 8'hFF,
            TL_ACCESS_ACK, 64'd0);
        wait_done("t6_backpressure", 100);
        a_stall_cfg = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
